sprite_line_buffer: RTL and testbench

Double-buffered (ping-pong) sprite line buffer: the memory behind the composer's sprite_lb_rdidx/sprite_lb_rddata/sprite_lb_erase_* interface, plus the write port driven by the sprite renderer.
- One bank is the display bank, read by the composer and then erased.
- The other bank is the render bank, written by the sprite renderer with first-writer-wins priority and collision detection.
- Banks swap on each line render start.

---
 rtl/sprite_line_buffer_pkg.sv | 41 ++++
 rtl/sprite_line_buffer_bank_ram.sv | 25 ++
 rtl/sprite_line_buffer.sv | 173 +++++++++++++++++
 tb/tb_sprite_line_buffer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_line_buffer_pkg.sv
// Shared entry layout and sizing for the sprite line buffer, so the composer and
// the sprite renderer decode line-buffer entries identically.
package sprite_line_buffer_pkg;

  localparam int LB_WIDTH  = 640;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 16;
  localparam int NUM_BANKS = 2;

  localparam int COLOR_LSB = 0;
  localparam int COLOR_W   = 8;
  localparam int Z_LSB     = 8;
  localparam int Z_W       = 2;
  localparam int MASK_LSB  = 12;
  localparam int MASK_W    = 4;

  typedef logic [DATA_W-1:0] lb_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_ERASE
  } erase_state_t;

  function automatic logic [COLOR_W-1:0] entry_color(input lb_entry_t e);
    return e[COLOR_LSB +: COLOR_W];
  endfunction

  function automatic logic [Z_W-1:0] entry_z(input lb_entry_t e);
    return e[Z_LSB +: Z_W];
  endfunction

  function automatic logic [MASK_W-1:0] entry_mask(input lb_entry_t e);
    return e[MASK_LSB +: MASK_W];
  endfunction

  // Color 0 is the transparent pixel value.
  function automatic logic entry_opaque(input lb_entry_t e);
    return |e[COLOR_LSB +: COLOR_W];
  endfunction

endpackage

// File: rtl/sprite_line_buffer_bank_ram.sv
// Simple dual-port line-buffer bank: one write port, one registered read port.
// Contents are never reset; a full erase defines them.
module lb_bank_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // Read-before-write on a shared address; the caller forwards where it matters.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/sprite_line_buffer.sv
// Ping-pong sprite line buffer: display bank read then erased by the composer,
// render bank written by the sprite renderer with first-writer-wins and collision masks.
module sprite_line_buffer #(
  parameter int LB_WIDTH = sprite_line_buffer_pkg::LB_WIDTH,
  parameter int ADDR_W   = sprite_line_buffer_pkg::ADDR_W
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      line_render_start,
  input  logic [ADDR_W-1:0]                         lb_rdidx,
  output logic [sprite_line_buffer_pkg::DATA_W-1:0] lb_rddata,
  input  logic                                      erase_start,
  output logic                                      erase_busy,
  input  logic                                      wr_en,
  input  logic [ADDR_W-1:0]                         wr_idx,
  input  logic [sprite_line_buffer_pkg::DATA_W-1:0] wr_data,
  output logic [sprite_line_buffer_pkg::MASK_W-1:0] sprite_collisions
);
  import sprite_line_buffer_pkg::*;

  localparam logic [ADDR_W:0]   LB_LIMIT = (ADDR_W+1)'(LB_WIDTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LB_WIDTH - 1);

  // bank_sel names the render bank; the other one is on display.
  logic              r_bank_sel;
  logic              w_disp_bank;

  logic              r_s1_valid;
  logic [ADDR_W-1:0] r_s1_idx;
  lb_entry_t         r_s1_data;
  logic              r_s1_bank;
  logic              r_s1_fwd;
  lb_entry_t         r_s1_fwd_data;

  logic [MASK_W-1:0] r_acc;
  logic [MASK_W-1:0] r_collisions;
  logic              r_rd_valid;
  logic              r_rd_bank;

  erase_state_t      r_state;
  logic              r_erase_bank;
  logic [ADDR_W-1:0] r_erase_cnt;
  logic              r_erase_busy;

  logic              w_wr_accept;
  lb_entry_t         w_existing;
  logic              w_new_opaque;
  logic              w_old_opaque;
  logic              w_s1_write;
  logic [MASK_W-1:0] w_s1_coll;
  logic              w_fwd_hit;

  logic              w_we    [NUM_BANKS];
  logic [ADDR_W-1:0] w_waddr [NUM_BANKS];
  lb_entry_t         w_wdata [NUM_BANKS];
  logic [ADDR_W-1:0] w_raddr [NUM_BANKS];
  lb_entry_t         w_rdata [NUM_BANKS];

  assign w_disp_bank = ~r_bank_sel;
  assign w_wr_accept = wr_en & ({1'b0, wr_idx} < LB_LIMIT);

  assign w_existing   = r_s1_fwd ? r_s1_fwd_data : w_rdata[r_s1_bank];
  assign w_new_opaque = entry_opaque(r_s1_data);
  assign w_old_opaque = entry_opaque(w_existing);
  assign w_s1_write   = r_s1_valid & w_new_opaque & ~w_old_opaque;
  assign w_s1_coll    = (r_s1_valid & w_new_opaque & w_old_opaque)
                      ? (entry_mask(w_existing) | entry_mask(r_s1_data))
                      : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      localparam logic BANK_ID = (gi != 0);
      logic w_erase_hit;
      logic w_s1_hit;

      assign w_erase_hit  = (r_state == ST_ERASE) & (r_erase_bank == BANK_ID);
      assign w_s1_hit     = w_s1_write & (r_s1_bank == BANK_ID);
      // Erase owns the write port whenever it targets this bank.
      assign w_we[gi]     = w_erase_hit | w_s1_hit;
      assign w_waddr[gi]  = w_erase_hit ? r_erase_cnt : r_s1_idx;
      assign w_wdata[gi]  = w_erase_hit ? '0 : r_s1_data;
      assign w_raddr[gi]  = (w_disp_bank == BANK_ID) ? lb_rdidx : wr_idx;

      lb_bank_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
      ) u_ram (
        .clk     (clk),
        .i_we    (w_we[gi]),
        .i_waddr (w_waddr[gi]),
        .i_wdata (w_wdata[gi]),
        .i_raddr (w_raddr[gi]),
        .o_rdata (w_rdata[gi])
      );
    end
  endgenerate

  // A write landing on the index being fetched this cycle would be missed by the RAM read.
  assign w_fwd_hit = w_we[r_bank_sel] & (w_waddr[r_bank_sel] == wr_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_sel    <= 1'b0;
      r_s1_valid    <= 1'b0;
      r_s1_idx      <= '0;
      r_s1_data     <= '0;
      r_s1_bank     <= 1'b0;
      r_s1_fwd      <= 1'b0;
      r_s1_fwd_data <= '0;
      r_acc         <= '0;
      r_collisions  <= '0;
      r_rd_valid    <= 1'b0;
      r_rd_bank     <= 1'b0;
    end else begin
      if (line_render_start) begin
        r_bank_sel   <= ~r_bank_sel;
        r_collisions <= r_acc | w_s1_coll;
        r_acc        <= '0;
      end else begin
        r_acc <= r_acc | w_s1_coll;
      end
      r_s1_valid    <= w_wr_accept;
      r_s1_idx      <= wr_idx;
      r_s1_data     <= wr_data;
      r_s1_bank     <= r_bank_sel;
      r_s1_fwd      <= w_fwd_hit;
      r_s1_fwd_data <= w_wdata[r_bank_sel];
      r_rd_valid    <= ({1'b0, lb_rdidx} < LB_LIMIT);
      r_rd_bank     <= w_disp_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_erase_bank <= 1'b0;
      r_erase_cnt  <= '0;
      r_erase_busy <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (erase_start) begin
            r_state      <= ST_ERASE;
            r_erase_bank <= w_disp_bank;
            r_erase_cnt  <= '0;
            r_erase_busy <= 1'b1;
          end
        end
        ST_ERASE: begin
          if (erase_start) begin
            r_erase_bank <= w_disp_bank;
            r_erase_cnt  <= '0;
          end else if (r_erase_cnt == LAST_IDX) begin
            r_state      <= ST_IDLE;
            r_erase_busy <= 1'b0;
          end else begin
            r_erase_cnt <= r_erase_cnt + 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_erase_busy <= 1'b0;
        end
      endcase
    end
  end

  assign lb_rddata         = r_rd_valid ? w_rdata[r_rd_bank] : '0;
  assign erase_busy        = r_erase_busy;
  assign sprite_collisions = r_collisions;

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Randomized bench for sprite_line_buffer against a per-pixel array model of both banks.
module tb_sprite_line_buffer;
  import sprite_line_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_render_start = 1'b0;
  logic [9:0]  lb_rdidx = '0;
  logic [15:0] lb_rddata;
  logic        erase_start = 1'b0;
  logic        erase_busy;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_idx = '0;
  logic [15:0] wr_data = '0;
  logic [3:0]  sprite_collisions;

  sprite_line_buffer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .line_render_start (line_render_start),
    .lb_rdidx          (lb_rdidx),
    .lb_rddata         (lb_rddata),
    .erase_start       (erase_start),
    .erase_busy        (erase_busy),
    .wr_en             (wr_en),
    .wr_idx            (wr_idx),
    .wr_data           (wr_data),
    .sprite_collisions (sprite_collisions)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mem[bank][pixel], sel = render bank, acc = running collision mask.
  logic [15:0] mem [2][640];
  int          sel;
  logic [3:0]  acc;
  logic [3:0]  coll_exp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input int b, input int idx, input logic [15:0] d);
    if (idx >= LB_WIDTH) return;
    if (d[7:0] == 8'h00) return;
    if (mem[b][idx][7:0] == 8'h00) mem[b][idx] = d;
    else acc = acc | mem[b][idx][15:12] | d[15:12];
  endtask

  task automatic cycle(input logic we, input int idx, input logic [15:0] d, input logic swap);
    int b;
    b = sel;
    wr_en = we;
    wr_idx = idx[9:0];
    wr_data = d;
    line_render_start = swap;
    if (swap) begin
      coll_exp = acc;
      acc = '0;
      sel = sel ^ 1;
    end
    if (we) model_write(b, idx, d);
    tick();
    wr_en = 1'b0;
    line_render_start = 1'b0;
    if (swap) check_eq("collisions", {28'h0, sprite_collisions}, {28'h0, coll_exp});
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 0, 16'h0, 1'b0);
  endtask

  task automatic rd_check(input int idx);
    logic [15:0] exp;
    lb_rdidx = idx[9:0];
    tick();
    if (idx < LB_WIDTH) exp = mem[sel ^ 1][idx];
    else exp = 16'h0000;
    check_eq($sformatf("rd[%0d]", idx), {16'h0, lb_rddata}, {16'h0, exp});
  endtask

  task automatic erase_run(input int restart_at, input int exp_busy);
    int busy;
    int c;
    busy = 0;
    c = 1;
    erase_start = 1'b1;
    tick();
    erase_start = 1'b0;
    for (int k = 0; k < LB_WIDTH; k++) mem[sel ^ 1][k] = 16'h0;
    while (c < 3000 && erase_busy) begin
      busy++;
      if (c == restart_at) erase_start = 1'b1;
      tick();
      erase_start = 1'b0;
      c++;
    end
    check_eq("erase_busy_cycles", busy, exp_busy);
  endtask

  function automatic logic [15:0] rand_entry();
    logic [7:0] color;
    color = ($urandom % 3 == 0) ? 8'h00 : 8'($urandom);
    return {4'($urandom), 2'b00, 2'($urandom), color};
  endfunction

  initial begin
    sel = 0;
    acc = '0;
    coll_exp = '0;
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < LB_WIDTH; k++) mem[b][k] = 16'h0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_rddata", {16'h0, lb_rddata}, 32'h0);
    check_eq("reset_busy", {31'h0, erase_busy}, 32'h0);
    check_eq("reset_coll", {28'h0, sprite_collisions}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Clear both banks and sweep them.
    erase_run(0, 640);
    cycle(1'b0, 0, 16'h0, 1'b1);
    erase_run(0, 640);
    for (int i = 0; i < LB_WIDTH; i++) rd_check(i);
    cycle(1'b0, 0, 16'h0, 1'b1);
    for (int i = 0; i < LB_WIDTH; i++) rd_check(i);

    // Single write, then neighbours and out-of-range read.
    cycle(1'b1, 5, 16'h1234, 1'b0);
    idle(2);
    cycle(1'b0, 0, 16'h0, 1'b1);
    rd_check(5);
    rd_check(6);
    rd_check(700);

    // Back-to-back same index: forwarding plus collision.
    cycle(1'b1, 10, 16'h2255, 1'b0);
    cycle(1'b1, 10, 16'h4266, 1'b0);
    idle(2);
    cycle(1'b0, 0, 16'h0, 1'b1);
    rd_check(10);

    // Transparent over opaque leaves the entry alone.
    cycle(1'b1, 3, 16'h0011, 1'b0);
    idle(2);
    cycle(1'b1, 3, 16'hF000, 1'b0);
    idle(2);
    cycle(1'b0, 0, 16'h0, 1'b1);
    rd_check(3);

    // Random render lines; each ends with a swap coinciding with the last write's S1.
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 40; c++) begin
        int idx;
        idx = ($urandom % 8 == 0) ? 640 + int'($urandom % 384) : int'($urandom % 16);
        cycle(($urandom % 4) != 0, idx, rand_entry(), (c == 20) && (r % 2 == 1));
      end
      cycle(1'b0, 0, 16'h0, 1'b1);
      idle(2);
      for (int i = 0; i < 16; i++) rd_check(i);
      rd_check(640 + int'($urandom % 384));
    end

    // Restarted erase.
    erase_run(100, 740);
    for (int i = 0; i < LB_WIDTH; i++) rd_check(i);

    // Distinct values at idx 600 in each bank reveal the post-reset display bank.
    cycle(1'b1, 600, 16'h00A1, 1'b0);
    idle(2);
    cycle(1'b0, 0, 16'h0, 1'b1);
    cycle(1'b1, 600, 16'h00B2, 1'b0);
    idle(2);
    cycle(1'b0, 0, 16'h0, 1'b1);

    cycle(1'b1, 1, 16'h1011, 1'b0);
    cycle(1'b1, 1, 16'h2022, 1'b0);
    idle(2);
    cycle(1'b0, 0, 16'h0, 1'b1);
    cycle(1'b1, 1, 16'h4033, 1'b0);
    cycle(1'b1, 1, 16'h8044, 1'b0);
    idle(2);

    // Async reset in the middle of an erase and a write burst.
    lb_rdidx = 10'd600;
    erase_start = 1'b1;
    tick();
    erase_start = 1'b0;
    repeat (30) cycle(1'b1, int'($urandom % 16), rand_entry(), 1'b0);
    wr_en = 1'b1;
    wr_idx = 10'd2;
    wr_data = 16'h30C5;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", {31'h0, erase_busy}, 32'h0);
    check_eq("midrst_rddata", {16'h0, lb_rddata}, 32'h0);
    check_eq("midrst_coll", {28'h0, sprite_collisions}, 32'h0);
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sel = 0;
    acc = '0;
    tick();
    rd_check(600);
    cycle(1'b0, 0, 16'h0, 1'b1);
    rd_check(600);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
